// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared definitions for the 2048 game front end and
//                controller: one-hot move codes, input-FSM state encodings
//                and a one-hot test helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // One-hot move codes, decoded identically by the game controller.
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b1000;

    // Input-stage FSM encodings. Code 2'b11 is unused and treated as illegal.
    typedef logic [1:0] in_state_t;
    localparam in_state_t ST_IDLE    = 2'b00;
    localparam in_state_t ST_HOLD    = 2'b01;
    localparam in_state_t ST_RELEASE = 2'b10;

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchronizer plus whole-vector debouncer for four
//                active-low push-buttons. The synchronized (active-high)
//                vector must remain unchanged for DEBOUNCE_CYCLES cycles
//                before it is published on key_stable.
//  Ports       : clock      - system clock
//                reset_n    - asynchronous active-low reset
//                keys_n     - raw buttons, active-low
//                key_stable - debounced pressed-key vector, active-high
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] keys_n,
    output logic [3:0] key_stable
);

    localparam int c_CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      w_key_s;
    logic [3:0]      r_candidate;
    logic [3:0]      r_stable;
    logic [c_CW-1:0] r_cnt;

    // Synchronizer flops reset to all-ones so the keys read as released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= keys_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_s = ~r_sync2;

    // One counter is shared by all four keys: any change anywhere in the
    // vector restarts the count, which also naturally filters chord edges.
    // Once the count reaches its last value it holds there (no wrap), so a
    // long-stable vector keeps being republished unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_candidate <= 4'b0000;
            r_stable    <= 4'b0000;
            r_cnt       <= '0;
        end else if (w_key_s != r_candidate) begin
            r_candidate <= w_key_s;
            r_cnt       <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_stable    <= r_candidate;
        end else begin
            r_cnt       <= r_cnt + 1'b1;
        end
    end

    assign key_stable = r_stable;

endmodule : key_debounce
`default_nettype wire

// File: rtl/direction_input.sv
`default_nettype none
// ============================================================================
//  Module      : direction_input
//  Description : Push-button front end for the 2048 game controller. Turns
//                the raw active-low buttons into a one-hot direction pulse
//                lasting HOLD_CYCLES clocks per accepted press; a new move
//                requires all keys to be released first, and chords are
//                dropped.
//  Build macro : AUTO_REPEAT_EN - when defined, a key held in RELEASE
//                re-fires after REPEAT_DELAY cycles, then every
//                REPEAT_PERIOD cycles. Undefined: one event per press.
//  Ports       : clock     - system clock
//                reset_n   - asynchronous active-low reset
//                keys_n    - raw buttons, active-low (0 L, 1 R, 2 D, 3 U)
//                enable    - controller accepting moves
//                direction - one-hot move output
//                key_event - single-cycle pulse on first direction cycle
//                busy      - FSM is not idle
//                state     - current FSM state (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module direction_input
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] keys_n,
    input  logic       enable,
    output logic [3:0] direction,
    output logic       key_event,
    output logic       busy,
    output logic [1:0] state
);

    // Reject nonsensical configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("direction_input: all timing parameters must be >= 1");
    end

    localparam int c_HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_CYCLES - 1);

    logic [3:0]      w_stable;
    in_state_t       r_state;
    logic [3:0]      r_dir;
    logic            r_event;
    logic [c_HW-1:0] r_hold_cnt;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock      (clock),
        .reset_n    (reset_n),
        .keys_n     (keys_n),
        .key_stable (w_stable)
    );

`ifdef AUTO_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                              : REPEAT_PERIOD;
    localparam int c_RW = $clog2(c_REP_MAX + 1);

    logic [3:0]      r_last_dir;
    logic            r_repeated;
    logic [c_RW-1:0] r_rep_cnt;
    logic [c_RW-1:0] w_rep_last;

    // The first repeat waits the longer delay; later ones use the period.
    assign w_rep_last = r_repeated ? c_RW'(REPEAT_PERIOD - 1)
                                   : c_RW'(REPEAT_DELAY - 1);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_dir      <= DIR_NONE;
            r_event    <= 1'b0;
            r_hold_cnt <= '0;
`ifdef AUTO_REPEAT_EN
            r_last_dir <= DIR_NONE;
            r_repeated <= 1'b0;
            r_rep_cnt  <= '0;
`endif
        end else begin
            // key_event only ever lasts the single cycle after a HOLD entry.
            r_event <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_stable != DIR_NONE) begin
                        if (is_onehot4(w_stable) && enable) begin
                            r_state    <= ST_HOLD;
                            r_dir      <= w_stable;
                            r_event    <= 1'b1;
                            r_hold_cnt <= '0;
`ifdef AUTO_REPEAT_EN
                            r_last_dir <= w_stable;
                            r_repeated <= 1'b0;
                            r_rep_cnt  <= '0;
`endif
                        end else begin
                            // Chord or disabled: drop the press and wait for
                            // a full release.
                            r_state <= ST_RELEASE;
                        end
                    end
                end

                ST_HOLD: begin
                    // Key activity is ignored here; only time and enable
                    // end the pulse.
                    if (!enable || (r_hold_cnt == c_HOLD_LAST)) begin
                        r_dir   <= DIR_NONE;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (w_stable == DIR_NONE) begin
                        r_state <= ST_IDLE;
`ifdef AUTO_REPEAT_EN
                        r_rep_cnt <= '0;
                    end else if (enable && (w_stable == r_last_dir)) begin
                        if (r_rep_cnt == w_rep_last) begin
                            r_state    <= ST_HOLD;
                            r_dir      <= r_last_dir;
                            r_event    <= 1'b1;
                            r_hold_cnt <= '0;
                            r_repeated <= 1'b1;
                            r_rep_cnt  <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end else begin
                        r_rep_cnt <= '0;
`endif
                    end
                end

                default: begin
                    // Illegal encoding: park safely and demand a release.
                    r_dir   <= DIR_NONE;
                    r_state <= ST_RELEASE;
                end
            endcase
        end
    end

    assign direction = r_dir;
    assign key_event = r_event;
    assign busy      = (r_state != ST_IDLE);
    assign state     = r_state;

endmodule : direction_input
`default_nettype wire

// File: tb/tb_direction_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_direction_input
//  Description : Self-checking bench for direction_input. A behavioural
//                model (key history run-length debouncer plus a move
//                sequencer) predicts every output each cycle; directed
//                scenarios add fixed-latency checks, then random stimulus
//                exercises presses, chords, bounce and enable changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_direction_input;

    localparam int DEBOUNCE_CYCLES = 16;
    localparam int HOLD_CYCLES     = 4;
    localparam int REPEAT_DELAY    = 64;
    localparam int REPEAT_PERIOD   = 32;
    localparam int c_LAT           = DEBOUNCE_CYCLES + 3;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] keys_n  = 4'b1111;
    logic       enable  = 1'b1;
    logic [3:0] direction;
    logic       key_event;
    logic       busy;
    logic [1:0] state;

    int n_total = 0;
    int n_bad   = 0;

    direction_input #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .keys_n    (keys_n),
        .enable    (enable),
        .direction (direction),
        .key_event (key_event),
        .busy      (busy),
        .state     (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Key history: p0/p1 are the pressed vectors seen one and two edges ago.
    logic [3:0] m_p0, m_p1, m_last, m_stable, m_dir;
    int         m_run;
    int         m_mode;   // 0 idle, 1 emitting, 2 waiting for release
    int         m_left;
    logic       m_ev;
`ifdef AUTO_REPEAT_EN
    logic [3:0] m_lastdir;
    int         m_rcnt;
    logic       m_rep;
`endif

    task automatic model_reset();
        m_p0 = 4'b0; m_p1 = 4'b0; m_last = 4'b0; m_stable = 4'b0;
        m_run = 1; m_mode = 0; m_left = 0; m_dir = 4'b0; m_ev = 1'b0;
`ifdef AUTO_REPEAT_EN
        m_lastdir = 4'b0; m_rcnt = 0; m_rep = 1'b0;
`endif
    endtask

    task automatic model_step(input logic [3:0] kn, input logic en);
        logic [3:0] ks;
        ks   = m_p1;
        m_ev = 1'b0;
        if (m_mode == 0) begin
            if (m_stable != 4'b0) begin
                if ($countones(m_stable) == 1 && en) begin
                    m_mode = 1; m_dir = m_stable; m_ev = 1'b1; m_left = HOLD_CYCLES;
`ifdef AUTO_REPEAT_EN
                    m_lastdir = m_stable; m_rep = 1'b0; m_rcnt = 0;
`endif
                end else begin
                    m_mode = 2;
                end
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (!en || m_left == 0) begin
                m_dir = 4'b0; m_mode = 2;
            end
        end else begin
            if (m_stable == 4'b0) begin
                m_mode = 0;
`ifdef AUTO_REPEAT_EN
                m_rcnt = 0;
            end else if (en && m_stable == m_lastdir) begin
                m_rcnt++;
                if (m_rcnt == (m_rep ? REPEAT_PERIOD : REPEAT_DELAY)) begin
                    m_mode = 1; m_dir = m_lastdir; m_ev = 1'b1;
                    m_left = HOLD_CYCLES; m_rep = 1'b1; m_rcnt = 0;
                end
            end else begin
                m_rcnt = 0;
`endif
            end
        end
        // A vector is accepted once it has been seen on DEBOUNCE_CYCLES+1
        // consecutive edges (reset counts as one sample of "released").
        if (ks == m_last) m_run++;
        else begin
            m_run = 1; m_last = ks;
        end
        if (m_run >= DEBOUNCE_CYCLES + 1) m_stable = ks;
        m_p1 = m_p0;
        m_p0 = ~kn;
    endtask

    // One clock: advance the model on the rising edge, compare on the
    // falling edge. Inputs are changed by callers after this returns.
    task automatic tick();
        @(posedge clock);
        if (reset_n) model_step(keys_n, enable);
        else         model_reset();
        @(negedge clock);
        chk("dir",   int'(direction), int'(m_dir));
        chk("event", int'(key_event), int'(m_ev));
        chk("state", int'(state),     m_mode);
        chk("busy",  int'(busy),      int'(m_mode != 0));
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int first, n_on, n_ev, seen;
    int ev_t[8];

    initial begin
        model_reset();

        // ---- reset with right key held ----
        keys_n = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_dir",   int'(direction), 0);
            chk("rst_event", int'(key_event), 0);
            chk("rst_state", int'(state),     0);
        end
        reset_n = 1'b1;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (first < 0 && direction != 4'b0) begin
                first = i;
                chk("rst_dircode", int'(direction), 2);
            end
        end
        chk("rst_latency", first, c_LAT);
        keys_n = 4'b1111;
        settle(40);

        // ---- clean left press ----
        keys_n = 4'b1110;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("clean_dir", int'(direction),
                (i >= c_LAT && i < c_LAT + HOLD_CYCLES) ? 1 : 0);
            chk("clean_event", int'(key_event), (i == c_LAT) ? 1 : 0);
            chk("clean_state", int'(state),
                (i < c_LAT) ? 0 : (i < c_LAT + HOLD_CYCLES) ? 1 : 2);
        end
        keys_n = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == c_LAT - 1) chk("rel_state_before", int'(state), 2);
            if (i == c_LAT)     chk("rel_state_after",  int'(state), 0);
        end
        settle(20);

        // ---- bounce on up key ----
        n_on = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 5 == 0) keys_n[3] = ~keys_n[3];
            tick();
            if (direction != 4'b0) n_on++;
        end
        chk("bounce_quiet", n_on, 0);
        keys_n = 4'b0111;
        first = -1; n_on = 0; n_ev = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (direction != 4'b0) begin
                n_on++;
                if (first < 0) first = i;
                chk("bounce_code", int'(direction), 8);
            end
            if (key_event) n_ev++;
        end
        chk("bounce_first", first, c_LAT);
        chk("bounce_len",   n_on,  HOLD_CYCLES);
        chk("bounce_event", n_ev,  1);
        keys_n = 4'b1111;
        settle(40);

        // ---- chord left+right ----
        keys_n = 4'b1100;
        n_on = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (direction != 4'b0) n_on++;
        end
        chk("chord_quiet", n_on, 0);
        chk("chord_state", int'(state), 2);
        keys_n = 4'b1111;
        settle(40);

        // ---- asynchronous reset during HOLD ----
        keys_n = 4'b1110;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            tick();
            if (direction != 4'b0) seen = 1;
        end
        chk("rhold_seen", seen, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rhold_dir",   int'(direction), 0);
        chk("rhold_state", int'(state),     0);
        model_reset();
        settle(2);
        reset_n = 1'b1;

        // ---- enable dropped during HOLD ----
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            tick();
            if (direction != 4'b0) seen = 1;
        end
        chk("en_seen", seen, 1);
        enable = 1'b0;
        tick();
        chk("en_dir",   int'(direction), 0);
        chk("en_state", int'(state),     2);
        keys_n = 4'b1111;
        settle(40);
        keys_n = 4'b1011;
        n_on = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (direction != 4'b0) n_on++;
        end
        chk("en_off_quiet", n_on, 0);
        chk("en_off_state", int'(state), 2);
        keys_n = 4'b1111;
        enable = 1'b1;
        settle(40);

        // ---- long hold of down: auto-repeat or single event ----
        keys_n = 4'b1011;
        n_ev = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (key_event) begin
                if (n_ev < 8) ev_t[n_ev] = i;
                n_ev++;
                chk("hold_code", int'(direction), 4);
            end
        end
        chk("hold_first", ev_t[0], c_LAT);
`ifdef AUTO_REPEAT_EN
        chk("hold_count", n_ev, 5);
        chk("hold_rep1", ev_t[1], c_LAT + HOLD_CYCLES + REPEAT_DELAY);
        chk("hold_rep2", ev_t[2], ev_t[1] + HOLD_CYCLES + REPEAT_PERIOD);
`else
        chk("hold_count", n_ev, 1);
`endif
        keys_n = 4'b1111;
        settle(40);

        // ---- random stimulus against the model ----
        for (int seg = 0; seg < 60; seg++) begin
            int kind, len, bit_i;
            kind  = $urandom_range(0, 3);
            len   = $urandom_range(1, 60);
            bit_i = $urandom_range(0, 3);
            enable = ($urandom_range(0, 7) != 0);
            case (kind)
                0: keys_n = 4'b1111;
                1: keys_n = ~(4'b0001 << bit_i);
                2: keys_n = 4'($urandom_range(0, 15));
                default: keys_n = 4'b1111;
            endcase
            for (int i = 0; i < len; i++) begin
                if (kind == 3 && $urandom_range(0, 2) == 0)
                    keys_n[bit_i] = ~keys_n[bit_i];
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_direction_input
`default_nettype wire
